// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO divider and the result-select mux:
// funct codes and the divider FSM state encoding.
package hilo_divider_pkg;

   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MTLO = 6'b010011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module hilo_divider_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_next_o,
   output logic [WIDTH-1:0] q_next_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   // The compare needs WIDTH+1 bits; the difference itself is always below
   // the divisor, so the low WIDTH bits of the subtraction are exact.
   assign shifted = {rem_i, q_i[WIDTH-1]};
   assign fits    = (shifted >= {1'b0, divisor_i});
   assign diff    = shifted[WIDTH-1:0] - divisor_i;

   always_comb begin
      rem_next_o = shifted[WIDTH-1:0];
      q_next_o   = {q_i[WIDTH-2:0], 1'b0};
      if (fits) begin
         rem_next_o = diff;
         q_next_o   = {q_i[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle unsigned divider owning the HI/LO pair (HI=remainder, LO=quotient).
// Optional MTHI/MTLO writes are compiled in when HILO_MOVE_EN is defined.
module hilo_divider
   import hilo_divider_pkg::*;
#(
   parameter int         WIDTH      = 32,
   parameter logic [5:0] DIVU_FUNCT = F_DIVU
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             done,
   output logic             divByZero,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic [1:0]       dbg_state
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic             is_divu;

   hilo_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i      (rem_q),
      .q_i        (quo_q),
      .divisor_i  (dvs_q),
      .rem_next_o (rem_nx),
      .q_next_o   (quo_nx)
   );

   assign is_divu = start && (Signal == DIVU_FUNCT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   // HI/LO are written on the edge that enters DONE, so during the one-cycle
   // DONE pulse the registers already hold the final result.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (is_divu) begin
               if (dataB != '0) begin
                  quo_d   = dataA;
                  dvs_d   = dataB;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_DIV;
               end else begin
                  hi_d    = dataA;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
`ifdef HILO_MOVE_EN
            else if (start && (Signal == F_MTHI)) begin
               hi_d = dataA;
            end else if (start && (Signal == F_MTLO)) begin
               lo_d = dataA;
            end
`endif
         end
         ST_DIV: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               hi_d    = rem_nx;
               lo_d    = quo_nx;
               dbz_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign divByZero = dbz_q;
   assign HiOut     = hi_q;
   assign LoOut     = lo_q;
   assign dbg_state = state_q;

endmodule
